// File: rtl/vx_boot_sequencer_if.sv
// Bus bundle between the boot sequencer and the surrounding bring-up logic.
// Carries the boot request, the memory-loader handshake and the DCR write bus.
// No backpressure anywhere: every signal is a plain level or a one-cycle strobe.

`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif

`ifndef VX_DCR_BASE_STARTUP_ADDR0
`define VX_DCR_BASE_STARTUP_ADDR0 12'h001
`endif

interface vx_boot_sequencer_if #(
  parameter int DCR_ADDR_WIDTH = `VX_DCR_ADDR_WIDTH,
  parameter int DCR_DATA_WIDTH = 32
);
  // control side
  logic                      start;
  logic [DCR_DATA_WIDTH-1:0] startup_addr;
  // memory loader handshake
  logic                      start_mem_loader;
  logic                      load_done;
  // DCR write bus
  logic                      dcr_write_valid;
  logic [DCR_ADDR_WIDTH-1:0] dcr_write_addr;
  logic [DCR_DATA_WIDTH-1:0] dcr_write_data;

  // sequencer side
  modport master (
    input  start,
    input  startup_addr,
    input  load_done,
    output start_mem_loader,
    output dcr_write_valid,
    output dcr_write_addr,
    output dcr_write_data
  );

  // control / loader / DCR-target side
  modport slave (
    output start,
    output startup_addr,
    output load_done,
    input  start_mem_loader,
    input  dcr_write_valid,
    input  dcr_write_addr,
    input  dcr_write_data
  );
endinterface

// File: rtl/vx_boot_sequencer.sv
// Boot/reset sequencer: mem reset -> loader run -> startup DCR write -> staged subsystem release.
// Latency: start to core release = MEM_RESET_CYCLES + load time + SUB_RESET_CYCLES + 3 cycles.
// No backpressure: start is ignored while busy, the DCR strobe is fire-and-forget.

module vx_boot_sequencer #(
  parameter int                        MEM_RESET_CYCLES  = 2,
  parameter int                        SUB_RESET_CYCLES  = 2,
  parameter int                        LOAD_TIMEOUT      = 4096,
  parameter int                        DCR_ADDR_WIDTH    = `VX_DCR_ADDR_WIDTH,
  parameter int                        DCR_DATA_WIDTH    = 32,
  parameter logic [DCR_ADDR_WIDTH-1:0] DCR_STARTUP_ADDR0 = `VX_DCR_BASE_STARTUP_ADDR0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_boot_sequencer_if.master  bus,
  output logic                 mem_reset,
  output logic                 mem_load_reset,
  output logic                 mem_arb_reset,
  output logic                 icache_reset,
  output logic                 dcache_reset,
  output logic                 gbar_reset,
  output logic                 core_reset,
  output logic                 busy,
  output logic                 ready,
  output logic                 timeout_err
);

  // one counter serves all timed states; sized for the longest wait so it never wraps
  localparam int MAX_AB  = (LOAD_TIMEOUT > MEM_RESET_CYCLES) ? LOAD_TIMEOUT : MEM_RESET_CYCLES;
  localparam int MAX_CYC = (MAX_AB > SUB_RESET_CYCLES) ? MAX_AB : SUB_RESET_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SUB_LAST  = CNT_W'(SUB_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_RST,
    S_LOAD,
    S_DCR,
    S_SUB_RST,
    S_CORE_REL,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DCR_DATA_WIDTH-1:0] addr_q, addr_d;

  // registered output copies and their next values
  logic                      mem_rst_q, mem_rst_d;
  logic                      sub_rst_q, sub_rst_d;
  logic                      core_rst_q, core_rst_d;
  logic                      launch_q, launch_d;
  logic                      dcr_vld_q, dcr_vld_d;
  logic [DCR_ADDR_WIDTH-1:0] dcr_addr_q, dcr_addr_d;
  logic [DCR_DATA_WIDTH-1:0] dcr_data_q, dcr_data_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;
  logic                      err_q, err_d;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, counter, address capture, and output values decoded from the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    mem_rst_d  = 1'b1;
    sub_rst_d  = 1'b1;
    core_rst_d = 1'b1;
    launch_d   = 1'b0;
    dcr_vld_d  = 1'b0;
    dcr_addr_d = '0;
    dcr_data_d = '0;
    busy_d     = 1'b0;
    ready_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (bus.start) begin
          state_d = S_MEM_RST;
          cnt_d   = CNT_ZERO;
          addr_d  = bus.startup_addr;
        end
      end
      S_MEM_RST: begin
        if (cnt_q == MEM_LAST) begin
          state_d = S_LOAD;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LOAD: begin
        // first LOAD cycle ignores a done left over from a previous run;
        // a done on the terminal-count cycle still beats the timeout
        if (bus.load_done && (cnt_q != CNT_ZERO)) begin
          state_d = S_DCR;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == LOAD_LAST) begin
          state_d = S_ERROR;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DCR: begin
        state_d = S_SUB_RST;
        cnt_d   = CNT_ZERO;
      end
      S_SUB_RST: begin
        if (cnt_q == SUB_LAST) begin
          state_d = S_CORE_REL;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CORE_REL: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // outputs are registered, so decode them from where the FSM is going
    case (state_d)
      S_MEM_RST: begin
        busy_d = 1'b1;
      end
      S_LOAD: begin
        mem_rst_d = 1'b0;
        busy_d    = 1'b1;
        launch_d  = (state_q != S_LOAD);
      end
      S_DCR: begin
        mem_rst_d  = 1'b0;
        busy_d     = 1'b1;
        dcr_vld_d  = 1'b1;
        dcr_addr_d = DCR_STARTUP_ADDR0;
        dcr_data_d = addr_d;
      end
      S_SUB_RST: begin
        mem_rst_d = 1'b0;
        busy_d    = 1'b1;
      end
      S_CORE_REL: begin
        mem_rst_d = 1'b0;
        sub_rst_d = 1'b0;
        busy_d    = 1'b1;
      end
      S_RUN: begin
        mem_rst_d  = 1'b0;
        sub_rst_d  = 1'b0;
        core_rst_d = 1'b0;
        ready_d    = 1'b1;
      end
      S_ERROR: begin
        err_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // counter, captured address and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      mem_rst_q  <= 1'b1;
      sub_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      launch_q   <= 1'b0;
      dcr_vld_q  <= 1'b0;
      dcr_addr_q <= '0;
      dcr_data_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      mem_rst_q  <= mem_rst_d;
      sub_rst_q  <= sub_rst_d;
      core_rst_q <= core_rst_d;
      launch_q   <= launch_d;
      dcr_vld_q  <= dcr_vld_d;
      dcr_addr_q <= dcr_addr_d;
      dcr_data_q <= dcr_data_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign mem_reset            = mem_rst_q;
  assign mem_load_reset       = mem_rst_q;
  assign mem_arb_reset        = sub_rst_q;
  assign icache_reset         = sub_rst_q;
  assign dcache_reset         = sub_rst_q;
  assign gbar_reset           = sub_rst_q;
  assign core_reset           = core_rst_q;
  assign busy                 = busy_q;
  assign ready                = ready_q;
  assign timeout_err          = err_q;
  assign bus.start_mem_loader = launch_q;
  assign bus.dcr_write_valid  = dcr_vld_q;
  assign bus.dcr_write_addr   = dcr_addr_q;
  assign bus.dcr_write_data   = dcr_data_q;

endmodule

// File: tb/tb_vx_boot_sequencer.sv
// Bench for vx_boot_sequencer: directed boot scenarios with hand-computed per-cycle outputs.
// Expected outputs and DCR writes are queued by the stimulus and checked by a negedge monitor.
// Cycle k of a scenario is the k-th clock period after the scenario's base edge.

module tb_vx_boot_sequencer;

  // {mem_reset, mem_load_reset, start_mem_loader, dcr_write_valid,
  //  mem_arb_reset, icache_reset, dcache_reset, gbar_reset,
  //  core_reset, busy, ready, timeout_err}
  localparam logic [11:0] V_IDLE  = 12'b1100_1111_1000;
  localparam logic [11:0] V_MEM   = 12'b1100_1111_1100;
  localparam logic [11:0] V_LOAD1 = 12'b0010_1111_1100;
  localparam logic [11:0] V_LOAD  = 12'b0000_1111_1100;
  localparam logic [11:0] V_DCR   = 12'b0001_1111_1100;
  localparam logic [11:0] V_SUB   = 12'b0000_1111_1100;
  localparam logic [11:0] V_CORE  = 12'b0000_0000_1100;
  localparam logic [11:0] V_RUN   = 12'b0000_0000_0010;
  localparam logic [11:0] V_ERR   = 12'b1100_1111_1001;
  localparam logic [11:0] A0      = 12'h001;

  typedef struct {
    int          cyc;
    logic [11:0] vec;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } dcr_t;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_reset, mem_load_reset, mem_arb_reset, icache_reset, dcache_reset, gbar_reset;
  logic core_reset, busy, ready, timeout_err;

  exp_t exp_q[$];
  dcr_t dcr_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   base  = 0;

  vx_boot_sequencer_if #(.DCR_ADDR_WIDTH(12), .DCR_DATA_WIDTH(32)) bus_if ();

  vx_boot_sequencer #(
    .MEM_RESET_CYCLES (2),
    .SUB_RESET_CYCLES (2),
    .LOAD_TIMEOUT     (8),
    .DCR_ADDR_WIDTH   (12),
    .DCR_DATA_WIDTH   (32),
    .DCR_STARTUP_ADDR0(12'h001)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus_if),
    .mem_reset     (mem_reset),
    .mem_load_reset(mem_load_reset),
    .mem_arb_reset (mem_arb_reset),
    .icache_reset  (icache_reset),
    .dcache_reset  (dcache_reset),
    .gbar_reset    (gbar_reset),
    .core_reset    (core_reset),
    .busy          (busy),
    .ready         (ready),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  wire [11:0] act_vec = {mem_reset, mem_load_reset, bus_if.start_mem_loader, bus_if.dcr_write_valid,
                         mem_arb_reset, icache_reset, dcache_reset, gbar_reset,
                         core_reset, busy, ready, timeout_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int k, input logic [11:0] v, input logic [31:0] d);
    exp_t e;
    dcr_t w;
    e.cyc  = base + k;
    e.vec  = v;
    e.addr = (v == V_DCR) ? A0 : 12'h000;
    e.data = (v == V_DCR) ? d : 32'h0;
    exp_q.push_back(e);
    if (v == V_DCR) begin
      w.addr = A0;
      w.data = d;
      dcr_q.push_back(w);
    end
  endtask

  task automatic expect_range(input int k0, input int k1, input logic [11:0] v);
    for (int k = k0; k <= k1; k++) expect_at(k, v, 32'h0);
  endtask

  task automatic do_reset();
    reset_n             = 1'b0;
    bus_if.start        = 1'b0;
    bus_if.load_done    = 1'b0;
    bus_if.startup_addr = 32'h0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // monitor: per-cycle output checks and DCR write scoreboard
  always @(negedge clk) begin
    exp_t e;
    dcr_t w;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      tests++;
      if (e.cyc != cyc || act_vec !== e.vec || bus_if.dcr_write_addr !== e.addr ||
          bus_if.dcr_write_data !== e.data) begin
        fails++;
        $display("FAIL outputs cyc=%0d (exp cyc %0d): got vec=%b addr=%h data=%h, want vec=%b addr=%h data=%h",
                 cyc, e.cyc, act_vec, bus_if.dcr_write_addr, bus_if.dcr_write_data, e.vec, e.addr, e.data);
      end
    end
    if (bus_if.dcr_write_valid === 1'b1) begin
      tests++;
      if (dcr_q.size() == 0) begin
        fails++;
        $display("FAIL dcr_write cyc=%0d: got unexpected write addr=%h data=%h, want no write",
                 cyc, bus_if.dcr_write_addr, bus_if.dcr_write_data);
      end else begin
        w = dcr_q.pop_front();
        if (bus_if.dcr_write_addr !== w.addr || bus_if.dcr_write_data !== w.data) begin
          fails++;
          $display("FAIL dcr_write cyc=%0d: got addr=%h data=%h, want addr=%h data=%h",
                   cyc, bus_if.dcr_write_addr, bus_if.dcr_write_data, w.addr, w.data);
        end
      end
    end
  end

  initial begin
    reset_n             = 1'b0;
    bus_if.start        = 1'b0;
    bus_if.load_done    = 1'b0;
    bus_if.startup_addr = 32'h0;

    // reset state, while held and just after release
    step();
    base = cyc;
    expect_at(0, V_IDLE, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    base = cyc;
    expect_range(0, 1, V_IDLE);
    step();
    step();

    // nominal boot
    do_reset();
    base = cyc;
    bus_if.startup_addr = 32'h8000_0000;
    expect_at(0, V_IDLE, 32'h0);
    expect_range(1, 2, V_MEM);
    expect_at(3, V_LOAD1, 32'h0);
    expect_range(4, 5, V_LOAD);
    expect_at(6, V_DCR, 32'h8000_0000);
    expect_range(7, 8, V_SUB);
    expect_at(9, V_CORE, 32'h0);
    expect_range(10, 11, V_RUN);
    for (int k = 0; k <= 11; k++) begin
      bus_if.start     = (k == 0);
      bus_if.load_done = (k == 5 || k == 6);
      step();
    end
    bus_if.start     = 1'b0;
    bus_if.load_done = 1'b0;

    // stale done held from before start
    do_reset();
    base = cyc;
    bus_if.startup_addr = 32'h2000_0000;
    expect_at(0, V_IDLE, 32'h0);
    expect_range(1, 2, V_MEM);
    expect_at(3, V_LOAD1, 32'h0);
    expect_at(4, V_LOAD, 32'h0);
    expect_at(5, V_DCR, 32'h2000_0000);
    expect_range(6, 7, V_SUB);
    expect_at(8, V_CORE, 32'h0);
    expect_at(9, V_RUN, 32'h0);
    for (int k = 0; k <= 9; k++) begin
      bus_if.start     = (k == 0);
      bus_if.load_done = (k <= 4);
      step();
    end
    bus_if.start     = 1'b0;
    bus_if.load_done = 1'b0;

    // load timeout, then restart from ERROR
    do_reset();
    base = cyc;
    bus_if.startup_addr = 32'h4000_0000;
    expect_at(0, V_IDLE, 32'h0);
    expect_range(1, 2, V_MEM);
    expect_at(3, V_LOAD1, 32'h0);
    expect_range(4, 10, V_LOAD);
    expect_range(11, 15, V_ERR);
    expect_range(16, 17, V_MEM);
    expect_at(18, V_LOAD1, 32'h0);
    for (int k = 0; k <= 18; k++) begin
      bus_if.start     = (k == 0 || k == 15);
      bus_if.load_done = 1'b0;
      step();
    end
    bus_if.start = 1'b0;

    // done arrives exactly on the terminal-count cycle
    do_reset();
    base = cyc;
    bus_if.startup_addr = 32'h6000_0000;
    expect_at(0, V_IDLE, 32'h0);
    expect_range(1, 2, V_MEM);
    expect_at(3, V_LOAD1, 32'h0);
    expect_range(4, 10, V_LOAD);
    expect_at(11, V_DCR, 32'h6000_0000);
    expect_range(12, 13, V_SUB);
    expect_at(14, V_CORE, 32'h0);
    expect_range(15, 16, V_RUN);
    for (int k = 0; k <= 16; k++) begin
      bus_if.start     = (k == 0);
      bus_if.load_done = (k == 10);
      step();
    end
    bus_if.start     = 1'b0;
    bus_if.load_done = 1'b0;

    // starts while busy are ignored; start in RUN reboots with a new address
    do_reset();
    base = cyc;
    expect_at(0, V_IDLE, 32'h0);
    expect_range(1, 2, V_MEM);
    expect_at(3, V_LOAD1, 32'h0);
    expect_range(4, 5, V_LOAD);
    expect_at(6, V_DCR, 32'h3000_0000);
    expect_range(7, 8, V_SUB);
    expect_at(9, V_CORE, 32'h0);
    expect_range(10, 12, V_RUN);
    expect_range(13, 14, V_MEM);
    expect_at(15, V_LOAD1, 32'h0);
    expect_at(16, V_LOAD, 32'h0);
    expect_at(17, V_DCR, 32'h0000_1000);
    expect_range(18, 19, V_SUB);
    expect_at(20, V_CORE, 32'h0);
    expect_at(21, V_RUN, 32'h0);
    for (int k = 0; k <= 21; k++) begin
      bus_if.start        = (k == 0 || k == 4 || k == 7 || k == 12);
      bus_if.startup_addr = (k == 0) ? 32'h3000_0000 : (k == 12) ? 32'h0000_1000 : 32'hDEAD_BEEF;
      bus_if.load_done    = (k == 5 || k == 16);
      step();
    end
    bus_if.start     = 1'b0;
    bus_if.load_done = 1'b0;

    // asynchronous reset in the middle of SUB_RST
    do_reset();
    base = cyc;
    bus_if.startup_addr = 32'h7000_0000;
    expect_at(0, V_IDLE, 32'h0);
    expect_range(1, 2, V_MEM);
    expect_at(3, V_LOAD1, 32'h0);
    expect_at(4, V_LOAD, 32'h0);
    expect_at(5, V_DCR, 32'h7000_0000);
    expect_range(6, 12, V_IDLE);
    for (int k = 0; k <= 12; k++) begin
      bus_if.start     = (k == 0);
      bus_if.load_done = (k == 4);
      if (k == 6) begin
        #2;
        reset_n = 1'b0;
      end
      if (k == 8) reset_n = 1'b1;
      step();
    end

    // everything queued must have been consumed
    step();
    step();
    tests++;
    if (exp_q.size() != 0 || dcr_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d output and %0d dcr expectations left, want 0 and 0",
               exp_q.size(), dcr_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vx_boot_sequencer.md
Name: vx_boot_sequencer

Overview:
Hardware boot/reset sequencer for a single-socket Vortex bring-up. On a start request it:
- holds all subsystems in reset;
- cycles memory and memory-loader reset, launches the memory loader and waits for completion;
- programs the startup-address DCR;
- releases mem-arbiter, icache, dcache and gbar reset, then core reset last.
It sits between the top-level control and the socket/memory subsystem resets and the DCR write bus.

Parameters:
MEM_RESET_CYCLES, 2, cycles mem/mem_load resets are held in MEM_RST (≥1)
SUB_RESET_CYCLES, 2, cycles SUB_RST lasts before cache/arb/gbar release (≥1)
LOAD_TIMEOUT, 4096, max cycles waiting for load_done before error (≥2)
DCR_ADDR_WIDTH, 12, DCR address width (`VX_DCR_ADDR_WIDTH)
DCR_DATA_WIDTH, 32, DCR data width
DCR_STARTUP_ADDR0, `VX_DCR_BASE_STARTUP_ADDR0, DCR address written with startup_addr

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  boot request; sampled only in IDLE, RUN or ERROR
startup_addr  in  DCR_DATA_WIDTH  code base address; captured on accepted start
load_done  in  1  memory loader completion (level or pulse)
mem_reset  out  1  active-high reset to memory model
mem_load_reset  out  1  active-high reset to memory loader
start_mem_loader  out  1  one-cycle loader launch pulse
dcr_write_valid  out  1  DCR write strobe, one cycle
dcr_write_addr  out  DCR_ADDR_WIDTH  DCR address
dcr_write_data  out  DCR_DATA_WIDTH  DCR data
mem_arb_reset, icache_reset, dcache_reset, gbar_reset  out  1 each  active-high subsystem resets
core_reset  out  1  active-high core reset
busy  out  1  sequence in progress
ready  out  1  boot complete, core running
timeout_err  out  1  load timed out

Behaviour:
Reset state:
- reset_n low → state IDLE.
- All seven subsystem resets = 1.
- start_mem_loader = 0, dcr_write_valid = 0, dcr_write_addr = 0, dcr_write_data = 0.
- busy = 0, ready = 0, timeout_err = 0.
- Counter and captured address cleared.

Outputs:
- Registered, Moore, decoded from the registered state.
- busy = 1 in MEM_RST, LOAD, DCR, SUB_RST and CORE_REL.

States:
- IDLE: all resets = 1. start → MEM_RST; capture startup_addr; clear counter.
- MEM_RST: all resets = 1. Stays exactly MEM_RESET_CYCLES cycles → LOAD.
- LOAD:
  - mem_reset and mem_load_reset = 0; other resets = 1.
  - start_mem_loader = 1 in the first LOAD cycle only.
  - load_done is ignored in that first cycle (stale-done guard) and sampled from the second cycle on.
  - load_done → DCR.
  - The counter counts LOAD cycles; reaching LOAD_TIMEOUT without load_done → ERROR.
  - load_done in the terminal-count cycle wins (→ DCR).
- DCR: one cycle. dcr_write_valid = 1, dcr_write_addr = DCR_STARTUP_ADDR0, dcr_write_data = captured address. No backpressure. → SUB_RST.
- SUB_RST: stays exactly SUB_RESET_CYCLES cycles, resets unchanged from LOAD → CORE_REL.
- CORE_REL: one cycle. mem_arb/icache/dcache/gbar resets = 0; core_reset still 1. → RUN.
- RUN: all resets = 0, ready = 1. start → MEM_RST (reboot): all resets reassert the next cycle, ready drops, new address captured.
- ERROR: timeout_err = 1, all resets = 1. start → MEM_RST and clears timeout_err.

Boundary conditions:
- start while busy is ignored.
- reset_n low mid-sequence returns immediately (asynchronously) to the IDLE output values.
- dcr_write_addr and dcr_write_data return to 0 outside DCR.
- Counter width is clog2(max(LOAD_TIMEOUT, MEM_RESET_CYCLES, SUB_RESET_CYCLES)) + 1 and never wraps.

Test Plan:
- Nominal, defaults, startup_addr = 0x80000000. start at edge 0, load_done high cycles 5–6 →
  - MEM_RST cycles 1–2.
  - start_mem_loader = 1 at cycle 3 only.
  - dcr_write_valid = 1 at cycle 6, addr = DCR_STARTUP_ADDR0, data = 0x80000000.
  - Cache/arb/gbar resets fall at cycle 9; core_reset falls and ready rises at cycle 10.
- Stale done: load_done held high from cycle 0 → ignored at cycle 3; DCR at cycle 5.
- Timeout: LOAD_TIMEOUT = 8, load_done never asserted →
  - ERROR at cycle 11 with timeout_err = 1 and all resets = 1.
  - start at cycle 15 → timeout_err = 0 at cycle 16.
- Boundary: load_done first asserted exactly on the terminal-count cycle → DCR taken, timeout_err stays 0.
- Ignored and reboot starts:
  - start pulses during LOAD and SUB_RST → no restart, dcr written once.
  - start in RUN with addr 0x1000 → ready = 0 and all resets = 1 next cycle; later DCR data = 0x1000.
- Async reset: reset_n low during SUB_RST → outputs return to IDLE values without a clock edge; no further DCR write after release.
